// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: first-word-fall-through FIFO of {ferr, data[8:0]}
// with fill level, level-threshold interrupt and sticky overrun flag.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned THRESH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_ferr,
  input  logic                     word,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic                     clr_ovr,
  output logic [8:0]               rd_data,
  output logic                     rd_ferr,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  output logic                     irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_overrun;

  logic          w_empty;
  logic          w_full;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic          w_drop;
  logic [9:0]    w_wr_entry;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));

  // A full FIFO still accepts a write when a read frees the head slot in the same cycle.
  assign w_rd_acc   = rd_en && !w_empty && !flush;
  assign w_wr_acc   = rx_valid && !flush && (!w_full || w_rd_acc);
  assign w_drop     = rx_valid && !flush && w_full && !w_rd_acc;
  assign w_wr_entry = {rx_ferr, word ? rx_data : {1'b0, rx_data[7:0]}};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_acc) begin
      r_mem[r_wptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A new drop takes priority over clr_ovr; flush leaves the flag alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_ovr) begin
      r_overrun <= 1'b0;
    end
  end

  assign rd_data = r_mem[r_rptr][8:0];
  assign rd_ferr = r_mem[r_rptr][9];
  assign empty   = w_empty;
  assign full    = w_full;
  assign level   = r_level;
  assign overrun = r_overrun;
  assign irq     = (r_level >= LW'(THRESH));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected {ferr,data} entries are queued
// as words are written and compared against the FIFO head as it is drained.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       word;
  logic       rd_en;
  logic       flush;
  logic       clr_ovr;
  logic [8:0] rd_data;
  logic       rd_ferr;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       overrun;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_e;

  uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .word(word), .rd_en(rd_en), .flush(flush), .clr_ovr(clr_ovr),
    .rd_data(rd_data), .rd_ferr(rd_ferr), .empty(empty), .full(full),
    .level(level), .overrun(overrun), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rx_valid = 0; rx_data = '0; rx_ferr = 0; rd_en = 0; flush = 0; clr_ovr = 0; rst = 0;
  endtask

  // Drives one word and records what the FIFO should hold for it.
  task automatic write(input logic [8:0] d, input logic f, input logic w, input bit expect_store);
    rx_valid = 1; rx_data = d; rx_ferr = f; word = w;
    if (expect_store) sb.push_back({f, w ? d : {1'b0, d[7:0]}});
    tick();
    rx_valid = 0; rx_ferr = 0;
  endtask

  task automatic pop_only();
    rd_en = 1;
    tick();
    rd_en = 0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({empty, full, level, overrun, irq} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got e=%0b f=%0b l=%0d o=%0b i=%0b, want e=1 f=0 l=0 o=0 i=0",
               empty, full, level, overrun, irq);
    end
  endtask

  task automatic test_basic_order();
    word = 0;
    write(9'h08E, 0, 0, 1);
    n_tests++;
    if (empty !== 1'b0 || rd_data !== 9'h08E) begin
      n_fail++; $display("FAIL write_latency: empty=%0b rd_data=%h, want 0 / 08e", empty, rd_data);
    end
    write(9'h081, 0, 0, 1);
    n_tests++;
    if (level !== 5'd2) begin n_fail++; $display("FAIL basic_level: got %0d want 2", level); end
    while (sb.size() > 0) begin
      exp_e = sb.pop_front();
      n_tests++;
      if ({rd_ferr, rd_data} !== exp_e) begin
        n_fail++; $display("FAIL basic_read: got %h want %h", {rd_ferr, rd_data}, exp_e);
      end
      pop_only();
    end
    n_tests++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %0b want 1", empty); end
  endtask

  task automatic test_width_mask();
    write(9'h1FE, 0, 1, 1);
    write(9'h1FE, 0, 0, 1);
    write(9'h055, 1, 0, 1);
    while (sb.size() > 0) begin
      exp_e = sb.pop_front();
      n_tests++;
      if ({rd_ferr, rd_data} !== exp_e) begin
        n_fail++; $display("FAIL width_mask: got %h want %h", {rd_ferr, rd_data}, exp_e);
      end
      pop_only();
    end
  endtask

  task automatic fill16(input logic [8:0] base);
    for (int i = 0; i < 16; i++) begin
      write(base + 9'(i), 0, 0, 1);
      n_tests++;
      if (irq !== ((i + 1) >= THRESH) || level !== 5'(i + 1)) begin
        n_fail++; $display("FAIL fill_irq_level: i=%0d irq=%0b level=%0d, want irq=%0b level=%0d",
                           i, irq, level, ((i + 1) >= THRESH), i + 1);
      end
    end
    n_tests++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b want 1", full); end
  endtask

  task automatic test_overrun();
    fill16(9'h000);
    write(9'h0AA, 0, 0, 0);
    n_tests++;
    if (overrun !== 1'b1 || level !== 5'd16) begin
      n_fail++; $display("FAIL overrun_set: overrun=%0b level=%0d, want 1 / 16", overrun, level);
    end
    while (sb.size() > 0) begin
      exp_e = sb.pop_front();
      n_tests++;
      if ({rd_ferr, rd_data} !== exp_e) begin
        n_fail++; $display("FAIL overrun_drain: got %h want %h", {rd_ferr, rd_data}, exp_e);
      end
      pop_only();
    end
    n_tests++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL overrun_empty: got %0b want 1", empty); end
    clr_ovr = 1; tick(); clr_ovr = 0;
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL clr_ovr: got %0b want 0", overrun); end
  endtask

  task automatic test_simul_full();
    fill16(9'h010);
    exp_e = sb.pop_front();
    n_tests++;
    if ({rd_ferr, rd_data} !== exp_e) begin
      n_fail++; $display("FAIL simul_full_head: got %h want %h", {rd_ferr, rd_data}, exp_e);
    end
    rd_en = 1;
    write(9'h033, 0, 0, 1);
    rd_en = 0;
    n_tests++;
    if (level !== 5'd16 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL simul_full: level=%0d overrun=%0b, want 16 / 0", level, overrun);
    end
    while (sb.size() > 0) begin
      exp_e = sb.pop_front();
      n_tests++;
      if ({rd_ferr, rd_data} !== exp_e) begin
        n_fail++; $display("FAIL simul_full_drain: got %h want %h", {rd_ferr, rd_data}, exp_e);
      end
      pop_only();
    end
  endtask

  task automatic test_simul_empty();
    rd_en = 1;
    write(9'h044, 0, 0, 1);
    rd_en = 0;
    exp_e = sb.pop_front();
    n_tests++;
    if (level !== 5'd1 || {rd_ferr, rd_data} !== exp_e) begin
      n_fail++; $display("FAIL simul_empty: level=%0d data=%h, want 1 / %h", level, {rd_ferr, rd_data}, exp_e);
    end
    pop_only();
    n_tests++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_empty_drain: got %0b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) write(9'h100 + 9'(i), 1'(i), 1, 1);
    for (int i = 0; i < 8; i++) begin
      exp_e = sb.pop_front();
      n_tests++;
      if ({rd_ferr, rd_data} !== exp_e) begin
        n_fail++; $display("FAIL b2b_head: i=%0d got %h want %h", i, {rd_ferr, rd_data}, exp_e);
      end
      rd_en = 1;
      write(9'h180 + 9'(i), 1'(i + 1), 1, 1);
      rd_en = 0;
      n_tests++;
      if (level !== 5'd4) begin n_fail++; $display("FAIL b2b_level: i=%0d got %0d want 4", i, level); end
    end
    while (sb.size() > 0) begin
      exp_e = sb.pop_front();
      n_tests++;
      if ({rd_ferr, rd_data} !== exp_e) begin
        n_fail++; $display("FAIL b2b_drain: got %h want %h", {rd_ferr, rd_data}, exp_e);
      end
      pop_only();
    end
  endtask

  // Leaves `keep` entries stored with overrun set.
  task automatic make_overrun(input int keep);
    fill16(9'h020);
    write(9'h0BB, 0, 0, 0);
    for (int i = 0; i < 16 - keep; i++) begin
      void'(sb.pop_front());
      pop_only();
    end
    n_tests++;
    if (overrun !== 1'b1 || level !== 5'(keep)) begin
      n_fail++; $display("FAIL prep_overrun: overrun=%0b level=%0d, want 1 / %0d", overrun, level, keep);
    end
  endtask

  task automatic test_flush();
    make_overrun(5);
    flush = 1;
    write(9'h0CC, 0, 0, 0);
    flush = 0;
    sb.delete();
    n_tests++;
    if (level !== 5'd0 || empty !== 1'b1 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL flush: level=%0d empty=%0b overrun=%0b, want 0 / 1 / 1", level, empty, overrun);
    end
    write(9'h012, 0, 0, 1);
    exp_e = sb.pop_front();
    n_tests++;
    if ({rd_ferr, rd_data} !== exp_e || level !== 5'd1) begin
      n_fail++; $display("FAIL flush_rewrite: data=%h level=%0d, want %h / 1", {rd_ferr, rd_data}, level, exp_e);
    end
    pop_only();
    clr_ovr = 1; tick(); clr_ovr = 0;
  endtask

  task automatic test_reset_mid();
    make_overrun(3);
    rst = 1;
    write(9'h077, 0, 0, 0);
    rst = 0;
    sb.delete();
    n_tests++;
    if ({empty, full, level, overrun, irq} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid: e=%0b f=%0b l=%0d o=%0b i=%0b, want e=1 f=0 l=0 o=0 i=0",
                         empty, full, level, overrun, irq);
    end
    tick();
    n_tests++;
    if (empty !== 1'b1 || level !== 5'd0) begin
      n_fail++; $display("FAIL reset_word_dropped: empty=%0b level=%0d, want 1 / 0", empty, level);
    end
  endtask

  initial begin
    idle();
    word = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    test_reset();
    test_basic_order();
    test_width_mask();
    test_overrun();
    test_simul_full();
    test_simul_empty();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer that sits directly downstream of `uart_rx` and consumes each received word before software or the host bus reads it. It stores the data word and its framing-error flag in a first-word-fall-through FIFO. It also reports the fill level, raises a level-threshold interrupt, and records overrun when a word arrives while the buffer is full.

## Interface
- `DEPTH`, 16: number of entries; power of two, minimum 2.
- `THRESH`, 8: `irq` asserts when `level >= THRESH`; legal range 1..DEPTH.
- `clk`  in  1  system clock; the same clock as `uart_rx`.
- `rst`  in  1  reset, synchronous and active-high.
- `rx_data`  in  9  received word from `uart_rx`; bit 8 is meaningful only in 9-bit mode.
- `rx_valid`  in  1  single-cycle pulse from `uart_rx`; `rx_data` and `rx_ferr` are valid in that cycle.
- `rx_ferr`  in  1  framing error (bad stop bit) for the word in the same cycle.
- `word`  in  1  `config_t.word`; 0 = 8-bit words, 1 = 9-bit words.
- `rd_en`  in  1  pop request; ignored while `empty`.
- `flush`  in  1  single-cycle request to discard all stored entries.
- `clr_ovr`  in  1  clears the `overrun` flag.
- `rd_data`  out  9  head entry data (first-word-fall-through).
- `rd_ferr`  out  1  framing-error flag of the head entry.
- `empty`  out  1  no entries stored.
- `full`  out  1  `level == DEPTH`.
- `level`  out  $clog2(DEPTH)+1  number of stored entries.
- `overrun`  out  1  sticky: at least one word was dropped because the FIFO was full.
- `irq`  out  1  `level >= THRESH`.

## Operation
- Storage: DEPTH x 10 bits, holding {ferr, data[8:0]}. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` is a separate registered counter.
- Write: on `rx_valid`, store `{rx_ferr, word ? rx_data : {1'b0, rx_data[7:0]}}`. Masking uses the value of `word` in the write cycle.
- Read: `rd_data`/`rd_ferr` always show the entry at the read pointer. They are don't-care while `empty`. `rd_en && !empty` advances the read pointer.
- Level update per cycle: +1 on an accepted write only; -1 on an accepted read only; unchanged when both or neither occur.
- Write while full:
  - With `rd_en` in the same cycle: the read is accepted and the write is accepted. `level` stays at DEPTH and `overrun` is not set.
  - Without `rd_en`: the word is dropped, `overrun` is set to 1, and the stored contents are unchanged.
- Write while empty with `rd_en` in the same cycle: `rd_en` is ignored, the write is accepted, and `level` becomes 1.
- `overrun` is cleared by `clr_ovr` or `rst`. If `clr_ovr` and a new drop occur in the same cycle, `overrun` stays 1 (set wins).
- `flush`:
  - Resets both pointers and `level` to 0 on the next edge.
  - Overrides `rx_valid` and `rd_en` in the same cycle; that word is discarded and `overrun` is not set.
  - Does not clear `overrun`.
- Framing-error entries are stored like any other entry; this block does not filter them.

## Timing
- Reset values: `empty`=1, `full`=0, `level`=0, `overrun`=0, `irq`=0, pointers 0. `rd_data`/`rd_ferr` are don't-care (0 after reset is preferred).
- `rst` asserted mid-operation discards all contents at the next edge, regardless of the other inputs.
- Write latency: `rx_valid` in cycle n makes `empty`, `level`, `full` and `irq` reflect the word in cycle n+1, with `rd_data` valid in n+1.
- Read latency: `rd_en` in cycle n presents the next entry on `rd_data` in cycle n+1. Back-to-back `rd_en` pops one entry per cycle.
- `empty`, `full` and `irq` are decoded from the registered `level`, with no combinational path from the inputs.
- `overrun` updates at the edge following the dropping `rx_valid`.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Basic order: `word`=0; write 0x08E then 0x081 with `rx_ferr`=0 → `level`=2. Read twice → 0x08E then 0x081, then `empty`=1.
- Width masking: write 0x1FE with `word`=1 → read 0x1FE. Write 0x1FE with `word`=0 → read 0x0FE. Write 0x055 with `rx_ferr`=1 → `rd_ferr`=1 with `rd_data`=0x055.
- Overrun: write 0x00..0x0F (16 words) → `full`=1, `irq`=1 from the 8th write. Write 0x0AA → `overrun`=1 and `level`=16. Drain → 0x00..0x0F in order, no 0x0AA. Pulse `clr_ovr` → `overrun`=0.
- Simultaneous at boundaries:
  - Full, with `rx_valid`=0x033 and `rd_en` in the same cycle → `level` stays 16 and `overrun`=0; 0x033 is the last word read.
  - Empty, with `rx_valid`=0x044 and `rd_en` → `level`=1 and `rd_data`=0x044.
- Flush: 5 entries stored, `overrun`=1; pulse `flush` together with `rx_valid` → `level`=0, `empty`=1, `overrun` still 1. The next write of 0x012 reads back as 0x012.
- Reset mid-stream: 3 entries stored, `overrun`=1; assert `rst` for one cycle with `rx_valid` high → all outputs at reset values, and the word presented in the reset cycle is not stored.
